// File: rtl/priority_code_decoder_if.sv
// Handshake and decoded-output bundle between the encoder link and the code decoder.
interface priority_code_decoder_if;
    logic [7:0]  code_in;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] onehot_out;
    logic        out_valid;

    modport master (
        output code_in,
        output code_valid,
        input  code_ready,
        input  onehot_out,
        input  out_valid
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output code_ready,
        output onehot_out,
        output out_valid
    );
endinterface

// File: rtl/priority_code_decoder.sv
// Buffers priority codes in a small FIFO and replays each as a one-hot vector held HOLD cycles.
module priority_code_decoder #(
    parameter int          DEPTH     = 4,
    parameter int          HOLD      = 4,
    parameter logic [7:0]  IDLE_CODE = 8'hF0
) (
    input  logic                     clk,
    input  logic                     rst,
    priority_code_decoder_if.slave   bus,
    output logic                     busy,
    output logic                     err_illegal,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [0:0] {S_IDLE, S_DRIVE} state_t;

    state_t          state_q;
    logic [HW-1:0]   hold_q;
    logic [15:0]     onehot_q;
    logic            out_valid_q;
    logic            err_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic [7:0]      mem_q [DEPTH];

    logic            accept;
    logic            legal;
    logic            push;
    logic            pop;
    logic [7:0]      head;

    function automatic logic [15:0] decode(input logic [7:0] c);
        if (c == IDLE_CODE) return 16'h0000;
        return 16'h0001 << c[3:0];
    endfunction

    // Ready is derived only from the registered count; a pop never frees a slot in the same cycle.
    assign bus.code_ready = (cnt_q != (AW+1)'(DEPTH));
    assign accept         = bus.code_valid & bus.code_ready;
    assign legal          = (bus.code_in < 8'd16) || (bus.code_in == IDLE_CODE);
    assign push           = accept & legal;
    assign head           = mem_q[rd_ptr_q];
    assign pop            = (cnt_q != '0) && ((state_q == S_IDLE) || (hold_q == '0));

    assign bus.onehot_out = onehot_q;
    assign bus.out_valid  = out_valid_q;
    assign err_illegal    = err_q;
    assign busy           = (state_q == S_DRIVE) || (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.code_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            onehot_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

            // An illegal accept outranks a concurrent clear.
            if (accept && !legal) err_q <= 1'b1;
            else if (err_clr)     err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        onehot_q    <= decode(head);
                        out_valid_q <= 1'b1;
                        hold_q      <= HW'(HOLD - 1);
                        state_q     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HW'(1);
                    end else if (pop) begin
                        onehot_q    <= decode(head);
                        out_valid_q <= 1'b1;
                        hold_q      <= HW'(HOLD - 1);
                    end else begin
                        onehot_q    <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_priority_code_decoder.sv
// Scoreboard bench for priority_code_decoder: driver queues expected vectors, monitor checks replay.
module tb_priority_code_decoder;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic busy;
    logic err_illegal;

    priority_code_decoder_if bus();

    priority_code_decoder #(.DEPTH(4), .HOLD(HOLD), .IDLE_CODE(8'hF0)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .err_illegal (err_illegal),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expq[$];
    int          run_len = 0;
    logic [15:0] cur = 16'h0;
    bit          saw_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_vec(input logic [7:0] c);
        if (c < 8'd16) return 16'h0001 << c;
        return 16'h0000;
    endfunction

    function automatic bit is_legal(input logic [7:0] c);
        return (c < 8'd16) || (c == 8'hF0);
    endfunction

    task automatic send(input logic [7:0] c);
        int n = 0;
        bus.code_in    = c;
        bus.code_valid = 1'b1;
        while (!bus.code_ready && n < 50) begin
            saw_full = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout code %0h never accepted", c);
        end
        if (is_legal(c)) expq.push_back(exp_vec(c));
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", (n < 200), 1);
    endtask

    // Monitor: one expected vector per HOLD consecutive valid cycles.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (bus.out_valid) begin
            if (run_len == 0) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_vec got %0h expected none", bus.onehot_out);
                end else begin
                    cur = expq.pop_front();
                end
            end
            chk("vec", bus.onehot_out, cur);
            chk("onehot_prop", ($countones(bus.onehot_out) <= 1), 1);
            run_len++;
            if (run_len == HOLD) run_len = 0;
        end else begin
            if (run_len != 0) begin
                checks++; errors++;
                $display("FAIL short_hold got %0d cycles expected %0d", run_len, HOLD);
            end
            run_len = 0;
            chk("idle_zero", bus.onehot_out, 16'h0);
        end
    end

    logic [7:0] t3_codes [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

    initial begin
        bus.code_valid = 1'b0;
        bus.code_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_onehot", bus.onehot_out, 16'h0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.code_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_illegal, 0);

        // Single code, latency and hold length
        send(8'd5);
        chk("t1_lat0", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("t1_vec", bus.onehot_out, 16'h0020);
        chk("t1_valid", bus.out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_vec_last", bus.onehot_out, 16'h0020);
        chk("t1_valid_last", bus.out_valid, 1);
        @(posedge clk); #1;
        chk("t1_drop", bus.out_valid, 0);
        chk("t1_busy", busy, 0);

        // Back-to-back vectors including the idle code
        send(8'd15);
        send(8'd0);
        send(8'hF0);
        wait_idle();
        chk("t2_drained", expq.size(), 0);

        // Fill the FIFO and wrap pointers
        saw_full = 1'b0;
        foreach (t3_codes[i]) send(t3_codes[i]);
        chk("t3_saw_full", saw_full, 1);
        wait_idle();
        chk("t3_drained", expq.size(), 0);

        // Illegal codes and sticky error
        send(8'd16);
        chk("t4_err_set", err_illegal, 1);
        send(8'hFF);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_no_out", bus.out_valid, 0);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t4_err_clr", err_illegal, 0);
        err_clr = 1'b1;
        send(8'h20);
        err_clr = 1'b0;
        chk("t4_set_wins", err_illegal, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t4_err_clr2", err_illegal, 0);

        // Reset mid-operation
        send(8'd9);
        send(8'd3);
        send(8'd7);
        chk("t5_hold2", bus.onehot_out, 16'h0200);
        rst = 1'b1;
        bus.code_in    = 8'd2;
        bus.code_valid = 1'b1;
        @(posedge clk); #1;
        chk("t5_onehot", bus.onehot_out, 16'h0);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", bus.code_ready, 1);
        expq.delete();
        rst = 1'b0;
        bus.code_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("t5_quiet", bus.out_valid, 0);
        end
        chk("t5_busy_after", busy, 0);

        // Mixed legal/illegal stream with gaps
        for (int i = 0; i < 60; i++) begin
            logic       v;
            logic [7:0] c;
            int         r;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 6)      c = 8'($urandom_range(0, 15));
            else if (r < 8) c = 8'hF0;
            else            c = 8'(16 + $urandom_range(0, 200));
            bus.code_in    = c;
            bus.code_valid = v;
            if (v && bus.code_ready && is_legal(c)) expq.push_back(exp_vec(c));
            @(posedge clk); #1;
        end
        bus.code_valid = 1'b0;
        wait_idle();
        chk("t6_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
